mux_4x1: RTL and testbench

//  4-to-1 multiplexer built from gate primitives (NOT/AND/OR), with a registered copy of its output.

---
 rtl/mux_4x1.sv | 56 +++++
 tb/tb_mux_4x1.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1.sv
// 4-to-1 multiplexer built from NOT/AND/OR primitives, one gate slice per data bit.
// y is the zero-latency combinational result; y_q is y captured on each rising clk edge.
module mux_4x1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    wire             s1_n;
    wire             s2_n;
    wire [WIDTH-1:0] y_gate;
    logic [WIDTH-1:0] y_q_d;

    // The inverted selects are shared by every bit slice.
    not u_not_s1 (s1_n, s1);
    not u_not_s2 (s2_n, s2);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            wire term_a;
            wire term_b;
            wire term_c;
            wire term_d;

            and u_and_a (term_a, s1_n, s2_n, a[gi]);
            and u_and_b (term_b, s1_n, s2,   b[gi]);
            and u_and_c (term_c, s1,   s2_n, c[gi]);
            and u_and_d (term_d, s1,   s2,   d[gi]);
            or  u_or_y  (y_gate[gi], term_a, term_b, term_c, term_d);
        end
    endgenerate

    assign y = y_gate;

    always_comb begin
        y_q_d = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_q_d;
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: expected y_q values queue up as vectors are driven
// and are popped after the capturing clock edge.
module tb_mux_4x1;

    logic clk;
    logic rst_n;
    logic a, b, c, d, s1, s2;
    logic y, y_q;

    int n_checks = 0;
    int n_fail   = 0;
    logic sb_q[$];

    mux_4x1 #(.WIDTH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .s1    (s1),
        .s2    (s2),
        .y     (y),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: pick the data input addressed by {s1,s2}.
    function automatic logic ref_mux(input logic [5:0] v);
        logic [3:0] din;
        logic [1:0] sel;
        din = {v[2], v[3], v[4], v[5]};   // index 0=a, 1=b, 2=c, 3=d
        sel = v[1:0];
        return din[sel];
    endfunction

    // Drive {a,b,c,d,s1,s2}, push the expected output for the next capture.
    task automatic drive(input logic [5:0] v, output logic exp_y);
        {a, b, c, d, s1, s2} = v;
        exp_y = ref_mux(v);
        sb_q.push_back(exp_y);
    endtask

    task automatic test_reset;
        logic exp_y;
        rst_n = 1'b0;
        @(negedge clk);
        drive(6'b1000_00, exp_y);
        #1;
        n_checks++;
        if (y !== exp_y) begin
            n_fail++;
            $display("FAIL reset_y_valid: y=%b required=%b", y, exp_y);
        end
        @(posedge clk);
        #1;
        void'(sb_q.pop_front());
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_y_q_held: y_q=%b required=0", y_q);
        end
        $display("txn reset: y=%b y_q=%b", y, y_q);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_sync: y_q=%b required=0", y_q);
        end
    endtask

    task automatic test_directed;
        logic [5:0] vecs [6];
        logic exp_y;
        logic exp_q;
        vecs[0] = 6'b1000_00;
        vecs[1] = 6'b0100_01;
        vecs[2] = 6'b0000_01;
        vecs[3] = 6'b0010_10;
        vecs[4] = 6'b0001_11;
        vecs[5] = 6'b0111_00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vecs[i], exp_y);
            #1;
            n_checks++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL directed_y[%0d]: y=%b required=%b", i, y, exp_y);
            end
            @(posedge clk);
            #1;
            exp_q = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_q) begin
                n_fail++;
                $display("FAIL directed_y_q[%0d]: y_q=%b required=%b", i, y_q, exp_q);
            end
            $display("txn directed %0d: abcd=%b s=%b y=%b y_q=%b", i, vecs[i][5:2], vecs[i][1:0], y, y_q);
        end
    endtask

    // All 64 input combinations, back to back, one capture per vector.
    task automatic test_exhaustive;
        logic exp_y;
        logic exp_q;
        logic [5:0] v;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            @(negedge clk);
            drive(v, exp_y);
            #1;
            n_checks++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL exhaustive_y[%0d]: y=%b required=%b", i, y, exp_y);
            end
            @(posedge clk);
            #1;
            exp_q = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_q) begin
                n_fail++;
                $display("FAIL exhaustive_y_q[%0d]: y_q=%b required=%b", i, y_q, exp_q);
            end
            $display("txn exhaustive %0d: abcd=%b s=%b y=%b y_q=%b", i, v[5:2], v[1:0], y, y_q);
        end
    endtask

    // Select c=0 and toggle the unselected inputs; y must stay 0.
    task automatic test_unselected_toggle;
        logic [5:0] v;
        logic exp_y;
        logic exp_q;
        for (int i = 0; i < 8; i++) begin
            v = {3'(i) == 3'd0 ? 3'b111 : 3'($urandom_range(0, 7)), 3'b0_10};
            v = {v[5], v[4], 1'b0, v[3], 2'b10};
            @(negedge clk);
            drive(v, exp_y);
            #1;
            n_checks++;
            if (y !== 1'b0) begin
                n_fail++;
                $display("FAIL unselected_y[%0d]: y=%b required=0", i, y);
            end
            @(posedge clk);
            #1;
            exp_q = sb_q.pop_front();
            n_checks++;
            if (y_q !== exp_q) begin
                n_fail++;
                $display("FAIL unselected_y_q[%0d]: y_q=%b required=%b", i, y_q, exp_q);
            end
            $display("txn unselected %0d: abcd=%b s=%b y=%b y_q=%b", i, v[5:2], v[1:0], y, y_q);
        end
    endtask

    task automatic test_async_reset;
        logic exp_y;
        @(negedge clk);
        drive(6'b1000_00, exp_y);
        @(posedge clk);
        #1;
        void'(sb_q.pop_front());
        n_checks++;
        if (y_q !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre_y_q: y_q=%b required=1", y_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear_y_q: y_q=%b required=0", y_q);
        end
        n_checks++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL async_clear_y: y=%b required=1", y);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_held_y_q: y_q=%b required=0", y_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (y_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release_y_q: y_q=%b required=0", y_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (y_q !== 1'b1) begin
            n_fail++;
            $display("FAIL async_recapture_y_q: y_q=%b required=1", y_q);
        end
        $display("txn async_reset: y=%b y_q=%b", y, y_q);
    endtask

    initial begin
        rst_n = 1'b0;
        {a, b, c, d, s1, s2} = 6'b0;
        test_reset();
        test_directed();
        test_exhaustive();
        test_unselected_toggle();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: entries=%0d required=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
